counter_sequence_monitor: RTL and testbench
===========================================

COUNTER_SEQUENCE_MONITOR -- requirements
Module: counter_sequence_monitor

Interface
REQ-001 Parameter LOCK_CNT, default 3, meaning: consecutive correct increments required to reach LOCKED (range 1..7).
REQ-002 Parameter STAT_W, default 8, meaning: width of the saturating statistics counters.
REQ-003 Port input_clock1_1  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port input_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port count_in  input  3  LED bus of the upstream 3-bit counter {led2,led1,led0}, synchronous to input_clock1_1.
REQ-006 Port clear_i  input  1  synchronous clear of statistics and sticky error.
REQ-007 Port locked_o  output  1  high while FSM is in LOCKED.
REQ-008 Port error_sticky_o  output  1  set on any sequence fault while LOCKED; held until clear_i or reset.
REQ-009 Port err_count_o  output  STAT_W  number of faults detected in LOCKED, saturating.
REQ-010 Port wrap_count_o  output  STAT_W  number of 7->0 wraps observed in LOCKED, saturating.
REQ-011 Port last_value_o  output  3  count_in value sampled at the previous edge.

Function
REQ-012 Every rising edge SHALL sample count_in into prev; "step OK" SHALL mean count_in == (prev + 1) mod 8, computed in 3 bits.
REQ-013 FSM states SHALL be IDLE, ACQUIRE, LOCKED, FAULT.
REQ-014 IDLE SHALL capture prev only, then move unconditionally to ACQUIRE with run = 0.
REQ-015 In ACQUIRE, step OK SHALL increment run; on step not OK, run SHALL return to 0 with no error recorded.
REQ-016 In ACQUIRE, when run reaches LOCK_CNT, the FSM SHALL enter LOCKED at that same edge; locked_o SHALL be registered and high from that edge.
REQ-017 In LOCKED, step not OK (including hold, skip, reversal) SHALL move to FAULT, set error_sticky_o, and increment err_count_o.
REQ-018 In LOCKED, step OK with prev == 7 and count_in == 0 SHALL increment wrap_count_o.
REQ-019 FAULT SHALL last exactly one cycle, then move to ACQUIRE with run = 0; relock requires LOCK_CNT new OK steps.
REQ-020 Statistics counters SHALL saturate at 2^STAT_W-1 and never wrap.
REQ-021 clear_i SHALL zero err_count_o, wrap_count_o, error_sticky_o at that edge; clear_i SHALL take priority over a fault or wrap event in the same cycle (the event is discarded); clear_i SHALL NOT affect FSM state, run, or prev.
REQ-022 Faults and wraps outside LOCKED SHALL not alter statistics.

Reset
REQ-023 While input_reset_n is low, all outputs SHALL be 0 immediately, FSM SHALL be IDLE, run and prev 0.
REQ-024 Reset asserted mid-operation (any state) SHALL abandon state without recording an error; after release, behaviour SHALL be as in REQ-014.

Structure
REQ-025 Package counter_monitor_pkg SHALL hold the state enum, the LOCK_CNT default, the STAT_W default, and the 3-bit count width constant.
REQ-026 One sub-module sat_counter (width parameter, inc, clr, async active-low reset, value out) SHALL be instantiated twice for err_count_o and wrap_count_o.
REQ-027 All outputs SHALL be driven directly from registers, with no combinational path from count_in to any output.

Verification
REQ-028 Reset release, count_in 0,1,2,3 on successive edges -> locked_o high after the edge sampling 3; err_count_o 0.
REQ-029 Locked, 16 further correct increments starting at 4 -> wrap_count_o = 2, error_sticky_o 0.
REQ-030 Locked, count_in jumps 3->5 -> at that edge locked_o 0, error_sticky_o 1, err_count_o 1; then 6,7,0,1 -> locked_o high again after the edge sampling 1 (FAULT cycle + 3 OK steps).
REQ-031 300 wraps while locked, STAT_W = 8 -> wrap_count_o = 255 and stays 255.
REQ-032 clear_i high on the same edge as a fault -> err_count_o 0, error_sticky_o 0, FSM in FAULT.
REQ-033 input_reset_n pulled low between edges while LOCKED -> all outputs 0 without a clock edge; relock follows REQ-028.

Source files
------------

// File: rtl/counter_monitor_pkg.sv
// counter_monitor_pkg: shared state encoding and default sizes for the counter sequence monitor
package counter_monitor_pkg;
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, FAULT} state_t;
  localparam int LOCK_CNT_DEF = 3;
  localparam int STAT_W_DEF = 8;
  localparam int CNT_W = 3;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);
  // clear wins over an increment; counting stops at all ones
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) value <= '0;
    else if (clr) value <= '0;
    else if (inc && value != '1) value <= value + W'(1);
endmodule

// File: rtl/counter_sequence_monitor.sv
// counter_sequence_monitor: checks a 3-bit counter bus for +1 steps and keeps fault/wrap statistics
module counter_sequence_monitor
  import counter_monitor_pkg::*;
#(
  parameter int LOCK_CNT = LOCK_CNT_DEF,
  parameter int STAT_W = STAT_W_DEF
) (
  input  logic              input_clock1_1,
  input  logic              input_reset_n,
  input  logic [CNT_W-1:0]  count_in,
  input  logic              clear_i,
  output logic              locked_o,
  output logic              error_sticky_o,
  output logic [STAT_W-1:0] err_count_o,
  output logic [STAT_W-1:0] wrap_count_o,
  output logic [CNT_W-1:0]  last_value_o
);
  localparam logic [CNT_W-1:0] LOCK_V = CNT_W'(LOCK_CNT);
  state_t state, state_n;
  logic [CNT_W-1:0] run, run_n;
  logic step_ok, fault, wrap;
  assign step_ok = count_in == last_value_o + CNT_W'(1);
  // next state: acquire a run of good steps, lock, and drop to a one-cycle fault on any bad step
  always_comb begin
    state_n = state;
    run_n = run;
    fault = 1'b0;
    wrap = 1'b0;
    case (state)
      IDLE: begin
        state_n = ACQUIRE;
        run_n = '0;
      end
      ACQUIRE: begin
        run_n = step_ok ? run + CNT_W'(1) : '0;
        state_n = step_ok && run + CNT_W'(1) == LOCK_V ? LOCKED : ACQUIRE;
      end
      LOCKED: begin
        fault = !step_ok;
        wrap = step_ok && last_value_o == 3'd7 && count_in == 3'd0;
        state_n = step_ok ? LOCKED : FAULT;
      end
      FAULT: begin
        state_n = ACQUIRE;
        run_n = '0;
      end
    endcase
  end
  // state, run, previous sample, registered lock flag and sticky error
  always_ff @(posedge input_clock1_1 or negedge input_reset_n)
    if (!input_reset_n) begin
      state <= IDLE;
      run <= '0;
      last_value_o <= '0;
      locked_o <= 1'b0;
      error_sticky_o <= 1'b0;
    end else begin
      state <= state_n;
      run <= run_n;
      last_value_o <= count_in;
      locked_o <= state_n == LOCKED;
      error_sticky_o <= clear_i ? 1'b0 : error_sticky_o | fault;
    end
  sat_counter #(.W(STAT_W)) u_err (
    .clk(input_clock1_1), .rst_n(input_reset_n), .inc(fault), .clr(clear_i), .value(err_count_o)
  );
  sat_counter #(.W(STAT_W)) u_wrap (
    .clk(input_clock1_1), .rst_n(input_reset_n), .inc(wrap), .clr(clear_i), .value(wrap_count_o)
  );
endmodule

// File: tb/tb_counter_sequence_monitor.sv
// tb_counter_sequence_monitor: directed vectors with a scoreboard queue and a decoupled monitor
module tb_counter_sequence_monitor;
  typedef struct packed {
    logic       l;
    logic       s;
    logic [7:0] e;
    logic [7:0] w;
    logic [2:0] v;
  } exp_t;
  logic clk = 1'b0;
  logic clk_en = 1'b1;
  logic rst_n = 1'b0;
  logic [2:0] count_in = 3'd5;
  logic clear = 1'b0;
  logic locked_o, error_sticky_o;
  logic [7:0] err_count_o, wrap_count_o;
  logic [2:0] last_value_o;
  exp_t q[$];
  string nq[$];
  int vectors = 0;
  int miscompares = 0;
  event sample_ev;
  counter_sequence_monitor dut (
    .input_clock1_1(clk), .input_reset_n(rst_n), .count_in(count_in), .clear_i(clear),
    .locked_o(locked_o), .error_sticky_o(error_sticky_o), .err_count_o(err_count_o),
    .wrap_count_o(wrap_count_o), .last_value_o(last_value_o)
  );
  always #5 if (clk_en) clk = ~clk;
  task automatic expect_v(input logic l, input logic s, input int e, input int w, input logic [2:0] v, input string n);
    q.push_back('{l: l, s: s, e: 8'(e), w: 8'(w), v: v});
    nq.push_back(n);
  endtask
  task automatic apply(input logic [2:0] v, input logic c, input logic l, input logic s, input int e, input int w, input string n);
    @(negedge clk);
    count_in = v;
    clear = c;
    expect_v(l, s, e, w, v, n);
  endtask
  initial begin
    exp_t x;
    string n;
    logic [20:0] got;
    forever begin
      @(posedge clk or sample_ev);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        n = nq.pop_front();
        got = {locked_o, error_sticky_o, err_count_o, wrap_count_o, last_value_o};
        vectors++;
        if (got !== x) begin
          miscompares++;
          $display("FAIL %s: got l=%0b s=%0b e=%0d w=%0d v=%0d, want l=%0b s=%0b e=%0d w=%0d v=%0d",
                   n, locked_o, error_sticky_o, err_count_o, wrap_count_o, last_value_o,
                   x.l, x.s, x.e, x.w, x.v);
        end
      end
    end
  end
  initial begin
    int w;
    repeat (2) @(negedge clk);
    expect_v(0, 0, 0, 0, 0, "reset_hold");
    ->sample_ev;
    @(negedge clk);
    rst_n = 1'b1;
    count_in = 3'd0;
    expect_v(0, 0, 0, 0, 0, "idle_capture");
    apply(1, 0, 0, 0, 0, 0, "acq1");
    apply(2, 0, 0, 0, 0, 0, "acq2");
    apply(3, 0, 1, 0, 0, 0, "lock");
    w = 0;
    for (int i = 0; i < 16; i++) begin
      w += ((4 + i) % 8 == 0) ? 1 : 0;
      apply(3'((4 + i) % 8), 0, 1, 0, 0, w, "run16");
    end
    apply(5, 0, 0, 1, 1, 2, "skip_fault");
    apply(6, 0, 0, 1, 1, 2, "fault_cycle");
    apply(7, 0, 0, 1, 1, 2, "reacq1");
    apply(0, 0, 0, 1, 1, 2, "reacq_nowrap");
    apply(1, 0, 1, 1, 1, 2, "relock");
    apply(1, 0, 0, 1, 2, 2, "hold_fault");
    apply(2, 0, 0, 1, 2, 2, "fault2");
    apply(3, 0, 0, 1, 2, 2, "acq_a");
    apply(4, 0, 0, 1, 2, 2, "acq_b");
    apply(5, 0, 1, 1, 2, 2, "relock2");
    apply(6, 1, 1, 0, 0, 0, "clear_locked");
    apply(4, 1, 0, 0, 0, 0, "clear_on_fault");
    apply(5, 0, 0, 0, 0, 0, "after_fault");
    apply(6, 0, 0, 0, 0, 0, "acq_c");
    apply(7, 0, 0, 0, 0, 0, "acq_d");
    apply(0, 0, 1, 0, 0, 0, "relock3");
    for (int i = 1; i < 8; i++) apply(3'(i), 0, 1, 0, 0, 0, "pre_clear_wrap");
    apply(0, 1, 1, 0, 0, 0, "clear_on_wrap");
    w = 0;
    for (int k = 0; k < 300; k++) begin
      for (int i = 1; i < 8; i++) apply(3'(i), 0, 1, 0, 0, w, "sat_run");
      w = (w < 255) ? w + 1 : 255;
      apply(0, 0, 1, 0, 0, w, "sat_wrap");
    end
    apply(1, 0, 1, 0, 0, 255, "sat_hold");
    @(negedge clk);
    clk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    expect_v(0, 0, 0, 0, 0, "async_reset");
    ->sample_ev;
    #5;
    rst_n = 1'b1;
    count_in = 3'd0;
    expect_v(0, 0, 0, 0, 0, "idle_after_reset");
    clk_en = 1'b1;
    apply(1, 0, 0, 0, 0, 0, "racq1");
    apply(2, 0, 0, 0, 0, 0, "racq2");
    apply(3, 0, 1, 0, 0, 0, "rlock");
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
